// File: rtl/bicubic_upsample_ctrl.sv
// Sequencing controller for the 4x bicubic upsample core: accepts 4x4 source windows,
// captures the core result and streams it as four row beats with line/frame markers.
module bicubic_upsample_ctrl #(
    parameter int CHANNEL_WIDTH   = 8,
    parameter int TILES_PER_LINE  = 960,
    parameter int LINES_PER_FRAME = 540
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        bf_req_valid,
    output logic                        bcci_req_ready,
    input  logic [16*CHANNEL_WIDTH-1:0] bf_req_data,
    output logic [16*CHANNEL_WIDTH-1:0] core_win,
    input  logic [16*CHANNEL_WIDTH-1:0] core_data,
    output logic                        bcci_rsp_valid,
    input  logic                        bf_rsp_ready,
    output logic [4*CHANNEL_WIDTH-1:0]  bcci_rsp_data,
    output logic [1:0]                  bcci_rsp_row,
    output logic                        bcci_rsp_eol,
    output logic                        bcci_rsp_eof
);
    // state | meaning
    // ------+-------------------------------------------------------
    // IDLE  | tile buffer empty, a window can be accepted
    // EMIT  | tile buffer holds a core result; r_q selects the beat

    localparam int PIX_W = 16 * CHANNEL_WIDTH;
    localparam int ROW_W = 4 * CHANNEL_WIDTH;
    localparam int COL_W = (TILES_PER_LINE > 1) ? $clog2(TILES_PER_LINE) : 1;
    localparam int LN_W  = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(TILES_PER_LINE - 1);
    localparam logic [LN_W-1:0]  LN_LAST  = LN_W'(LINES_PER_FRAME - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_nxt;
    logic [1:0]       r_q;
    logic [1:0]       r_nxt;
    logic [COL_W-1:0] col_q;
    logic [LN_W-1:0]  ln_q;
    logic [PIX_W-1:0] tile_q;
    logic [ROW_W-1:0] row_sel;

    logic emit;
    logic last_row;
    logic req_hs;
    logic rsp_hs;
    logic tile_done;
    logic col_last;
    logic ln_last;

    assign emit      = (state_q == EMIT);
    assign last_row  = (r_q == 2'd3);
    assign col_last  = (col_q == COL_LAST);
    assign ln_last   = (ln_q == LN_LAST);

    // A new window may land in the same cycle the final row leaves, so tiles stream without bubbles.
    assign bcci_req_ready = !rst & (!emit | (last_row & bf_rsp_ready));
    assign req_hs         = bf_req_valid & bcci_req_ready;
    assign rsp_hs         = emit & bf_rsp_ready;
    assign tile_done      = rsp_hs & last_row;

    assign core_win = bf_req_data;

    always_comb begin
        state_nxt = state_q;
        r_nxt     = r_q;
        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    state_nxt = EMIT;
                    r_nxt     = 2'd0;
                end
            end
            EMIT: begin
                if (tile_done) begin
                    state_nxt = req_hs ? EMIT : IDLE;
                    r_nxt     = 2'd0;
                end else if (rsp_hs) begin
                    r_nxt = r_q + 2'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                r_nxt     = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= 2'd0;
            col_q   <= '0;
            ln_q    <= '0;
            tile_q  <= '0;
        end else begin
            state_q <= state_nxt;
            r_q     <= r_nxt;
            if (req_hs) begin
                tile_q <= core_data;
            end
            if (tile_done) begin
                if (col_last) begin
                    col_q <= '0;
                    ln_q  <= ln_last ? '0 : ln_q + LN_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
        end
    end

    always_comb begin
        row_sel = '0;
        case (r_q)
            2'd0:    row_sel = tile_q[0*ROW_W +: ROW_W];
            2'd1:    row_sel = tile_q[1*ROW_W +: ROW_W];
            2'd2:    row_sel = tile_q[2*ROW_W +: ROW_W];
            default: row_sel = tile_q[3*ROW_W +: ROW_W];
        endcase
    end

    // Payload is forced to zero whenever no beat is offered.
    assign bcci_rsp_valid = emit;
    assign bcci_rsp_data  = emit ? row_sel : '0;
    assign bcci_rsp_row   = emit ? r_q : 2'd0;
    assign bcci_rsp_eol   = emit & col_last;
    assign bcci_rsp_eof   = emit & last_row & col_last & ln_last;

endmodule

// File: doc/bicubic_upsample_ctrl.md
# bicubic_upsample_ctrl

Sequencing controller for the 4x bicubic upsample core. It accepts one 4x4 source window per handshake and drives that window onto the combinational core. It captures the core's 16 output pixels and streams them downstream as four row beats of 4 pixels each, with valid/ready backpressure. It also tracks tile column and source line so the frame writer receives end-of-line and end-of-frame markers. It sits between the line-buffer window fetcher (upstream) and the output frame writer (downstream).

## Interface
Parameters:
- CHANNEL_WIDTH, 8: bits per pixel channel.
- TILES_PER_LINE, 960: windows per source line (minimum 1).
- LINES_PER_FRAME, 540: source lines per frame (minimum 1).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- bf_req_valid  in  1  upstream window valid.
- bcci_req_ready  out  1  controller can accept a window this cycle.
- bf_req_data  in  16*CHANNEL_WIDTH  window p1..p16, p1 in LSBs, row-major (p1..p4 = top row).
- core_win  out  16*CHANNEL_WIDTH  window to core; equals bf_req_data.
- core_data  in  16*CHANNEL_WIDTH  core outputs data1..data16, data1 in LSBs.
- bcci_rsp_valid  out  1  output row beat valid.
- bf_rsp_ready  in  1  downstream accepts beat.
- bcci_rsp_data  out  4*CHANNEL_WIDTH  one output row of 4 pixels, leftmost in LSBs.
- bcci_rsp_row  out  2  row index 0..3 within current tile.
- bcci_rsp_eol  out  1  beat belongs to last tile of a source line.
- bcci_rsp_eof  out  1  beat is row 3 of the last tile of the frame.

## Operation
- Handshakes: req_hs = bf_req_valid & bcci_req_ready; rsp_hs = bcci_rsp_valid & bf_rsp_ready.
- State machine:
  - IDLE: buffer empty.
  - EMIT: buffer holds a tile; row counter r selects the beat.
- bcci_req_ready = !rst & (state==IDLE | (r==3 & bf_rsp_ready)). This is combinational.
- On req_hs, the controller captures core_data into the 16-pixel tile buffer, sets r=0, and enters or stays in EMIT. core_data is sampled only on req_hs.
- In EMIT:
  - bcci_rsp_valid=1.
  - bcci_rsp_data = data(4r+1)..data(4r+4).
  - bcci_rsp_row = r.
- On rsp_hs with r<3: r increments.
- On rsp_hs with r==3: return to IDLE, unless req_hs occurs the same cycle, in which case reload the buffer and set r=0.
- Tile column counter col (0..TILES_PER_LINE-1) and line counter ln (0..LINES_PER_FRAME-1):
  - Both advance on rsp_hs with r==3.
  - col wraps to 0 after the last tile, and ln increments on that wrap.
  - ln wraps to 0 after the last line.
- bcci_rsp_eol = valid & col==TILES_PER_LINE-1, asserted on all four beats of that tile.
- bcci_rsp_eof = valid & r==3 & col==last & ln==last.
- Counter widths are $clog2 of each parameter, minimum 1 bit.
- The tile buffer, r, and all output payload fields hold stable while bcci_rsp_valid & !bf_rsp_ready.

## Timing
- Reset (rst high at a clock edge):
  - state=IDLE, r=0, col=0, ln=0, buffer=0.
  - bcci_rsp_valid=0, bcci_rsp_data=0, bcci_rsp_row=0, eol=0, eof=0.
  - bcci_req_ready=0 while rst is high.
- Latency: req_hs at edge T; row 0 is valid in the cycle after T.
- Throughput: one tile per 4 cycles with ready held high. The row-3 handshake and a new req_hs may coincide, giving no bubble between tiles.
- While in EMIT with r<3, bcci_req_ready=0. Upstream must hold its window.
- Reset mid-tile discards the buffered tile and the counters. The first tile after reset is col 0, ln 0.
- TILES_PER_LINE=1: eol is asserted on every tile. TILES_PER_LINE=1 with LINES_PER_FRAME=1: eof is asserted on row 3 of every tile.
- bf_rsp_ready asserted while bcci_rsp_valid=0 has no effect.

## Test plan
The bench ties core_data = core_win (identity stub) and uses byte pixel value pk = k.

- Single tile, ready held at 1: accept window 1..16 -> beats {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} with rows 0..3 on 4 consecutive cycles starting 1 cycle after accept; bcci_req_ready=1 again in the row-3 cycle.
- Back-to-back: upstream valid continuously with 3 tiles -> 12 beats with no bubble; bcci_req_ready pulses only in row-3 cycles.
- Backpressure: bf_rsp_ready low for 5 cycles at row 1 -> row 1 data {5,6,7,8} held stable, row stays 1, bcci_req_ready=0, then resumes.
- Counters: TILES_PER_LINE=3, LINES_PER_FRAME=2, 6 tiles -> eol on all beats of tiles 3 and 6; eof only on row 3 of tile 6; the 7th tile has col=0 and no eol.
- Reset mid-tile: assert rst at row 2 -> next cycle valid=0, data=0, ready=0; after release, ready=1 and the next tile restarts at col 0.
- Degenerate: TILES_PER_LINE=1, LINES_PER_FRAME=1 -> eol on every beat, eof on every row-3 beat.
